// File: rtl/select_encode_unit_if.sv
// Bundle between the control unit / IR bus and the select-and-encode stage.
// master = control-unit side, slave = select_encode_unit.
interface select_encode_unit_if #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned OPC_LSB  = 27
);
  logic                       ir_load;
  logic [DATA_W-1:0]          ir_in;
  logic                       gra;
  logic                       grb;
  logic                       grc;
  logic                       rin;
  logic                       rout;
  logic                       baout;
  logic [DATA_W-OPC_LSB-1:0]  opcode;
  logic [DATA_W-1:0]          c_sign_extended;
  logic [NUM_REGS-1:0]        reg_in;
  logic [NUM_REGS-1:0]        reg_out;
  logic                       ba_zero;
  logic                       sel_err;
  logic                       valid_out;

  modport master (
    output ir_load, ir_in, gra, grb, grc, rin, rout, baout,
    input  opcode, c_sign_extended, reg_in, reg_out, ba_zero, sel_err, valid_out
  );

  modport slave (
    input  ir_load, ir_in, gra, grb, grc, rin, rout, baout,
    output opcode, c_sign_extended, reg_in, reg_out, ba_zero, sel_err, valid_out
  );
endinterface

// File: rtl/select_encode_unit.sv
// Instruction register plus Ra/Rb/Rc select-and-encode with registered one-hot enables.
// Optional macro SELENC_IR_BYPASS_EN forwards ir_in into field selection on a load cycle.
module select_encode_unit #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned IDX_W    = 4,
  parameter int unsigned OPC_LSB  = 27,
  parameter int unsigned RA_LSB   = 23,
  parameter int unsigned RB_LSB   = 19,
  parameter int unsigned RC_LSB   = 15,
  parameter int unsigned IMM_W    = 19
) (
  input  logic                  clock,
  input  logic                  clear,
  select_encode_unit_if.slave   bus
);

  localparam int unsigned EXT_W = DATA_W - IMM_W;
  localparam logic [IDX_W:0] NUM_REGS_L = (IDX_W+1)'(NUM_REGS);

  logic [DATA_W-1:0]   ir;
  logic [IDX_W-1:0]    ra_c;
  logic [IDX_W-1:0]    rb_c;
  logic [IDX_W-1:0]    rc_c;
  logic [IDX_W-1:0]    idx_c;
  logic                multi_c;
  logic                oor_c;
  logic                idx_zero_c;
  logic                any_c;
  logic [NUM_REGS-1:0] onehot_c;
  logic [NUM_REGS-1:0] reg_in_q;
  logic [NUM_REGS-1:0] reg_out_q;
  logic                ba_zero_q;
  logic                sel_err_q;
  logic                valid_q;

  // Instruction register
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      ir <= '0;
    end else if (bus.ir_load) begin
      ir <= bus.ir_in;
    end
  end

  assign bus.opcode          = ir[DATA_W-1:OPC_LSB];
  assign bus.c_sign_extended = {{EXT_W{ir[IMM_W-1]}}, ir[IMM_W-1:0]};

  // Field source: the forwarded bus value only matters on a load cycle
`ifdef SELENC_IR_BYPASS_EN
  assign ra_c = bus.ir_load ? bus.ir_in[RA_LSB +: IDX_W] : ir[RA_LSB +: IDX_W];
  assign rb_c = bus.ir_load ? bus.ir_in[RB_LSB +: IDX_W] : ir[RB_LSB +: IDX_W];
  assign rc_c = bus.ir_load ? bus.ir_in[RC_LSB +: IDX_W] : ir[RC_LSB +: IDX_W];
`else
  assign ra_c = ir[RA_LSB +: IDX_W];
  assign rb_c = ir[RB_LSB +: IDX_W];
  assign rc_c = ir[RC_LSB +: IDX_W];
`endif

  // Priority gra > grb > grc; no strobe falls back to R0
  always_comb begin
    idx_c = '0;
    if (bus.gra) begin
      idx_c = ra_c;
    end else if (bus.grb) begin
      idx_c = rb_c;
    end else if (bus.grc) begin
      idx_c = rc_c;
    end
  end

  assign multi_c    = (bus.gra & bus.grb) | (bus.gra & bus.grc) | (bus.grb & bus.grc);
  assign oor_c      = {1'b0, idx_c} >= NUM_REGS_L;
  assign idx_zero_c = (idx_c == '0);
  assign any_c      = bus.rin | bus.rout | bus.baout;

  // Decoder yields all-zero for an out-of-range index, so at most one bit is ever set
  always_comb begin
    onehot_c = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (IDX_W'(i) == idx_c) begin
        onehot_c[i] = 1'b1;
      end
    end
  end

  // Output register: single-cycle pulses, aborted by clear
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      reg_in_q  <= '0;
      reg_out_q <= '0;
      ba_zero_q <= 1'b0;
      sel_err_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      reg_in_q  <= oor_c ? '0 : (onehot_c & {NUM_REGS{bus.rin}});
      reg_out_q <= (oor_c | (bus.baout & idx_zero_c)) ? '0
                 : (onehot_c & {NUM_REGS{bus.rout | bus.baout}});
      ba_zero_q <= bus.baout & ~oor_c & idx_zero_c;
      sel_err_q <= (multi_c | oor_c) & any_c;
      valid_q   <= any_c;
    end
  end

  assign bus.reg_in    = reg_in_q;
  assign bus.reg_out   = reg_out_q;
  assign bus.ba_zero   = ba_zero_q;
  assign bus.sel_err   = sel_err_q;
  assign bus.valid_out = valid_q;

endmodule

// File: tb/tb_select_encode_unit.sv
// Bench for select_encode_unit: a 16-register and an 8-register instance driven in lockstep.
module tb_select_encode_unit;

  logic clock = 1'b0;
  logic clear;
  int   n_checks = 0;
  int   n_fail   = 0;

  select_encode_unit_if #(.DATA_W(32), .NUM_REGS(16), .OPC_LSB(27)) bus  ();
  select_encode_unit_if #(.DATA_W(32), .NUM_REGS(8),  .OPC_LSB(27)) bus8 ();

  select_encode_unit u_dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  select_encode_unit #(.NUM_REGS(8)) u_dut8 (
    .clock (clock),
    .clear (clear),
    .bus   (bus8)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] make_ir(input int op, input int ra, input int rb,
                                          input int rc, input int low);
    return 32'((op << 27) | (ra << 23) | (rb << 19) | (rc << 15) | (low & 32'h7FFF));
  endfunction

  // Reference: decide the selected register from the rules, then form the vectors
  function automatic void model(input logic [31:0] ir_v, input logic [31:0] din, input bit ld,
                                input bit a, input bit b, input bit c,
                                input bit ri, input bit ro, input bit ba, input int nr,
                                output logic [15:0] e_in, output logic [15:0] e_out,
                                output bit e_ba, output bit e_err, output bit e_valid);
    logic [31:0] src;
    int idx;
    bit oor;
    src = ir_v;
`ifdef SELENC_IR_BYPASS_EN
    if (ld) src = din;
`endif
    idx = 0;
    if (a)      idx = int'((src >> 23) & 32'hF);
    else if (b) idx = int'((src >> 19) & 32'hF);
    else if (c) idx = int'((src >> 15) & 32'hF);
    oor     = (idx >= nr);
    e_valid = ri | ro | ba;
    e_err   = e_valid && ((int'(a) + int'(b) + int'(c)) > 1 || oor);
    e_ba    = ba && !oor && idx == 0;
    e_in    = (!oor && ri) ? 16'(1 << idx) : 16'h0;
    e_out   = (!oor && (ro || ba) && !(ba && idx == 0)) ? 16'(1 << idx) : 16'h0;
  endfunction

  task automatic set_ctl(input bit ld, input logic [31:0] din, input bit a, input bit b,
                         input bit c, input bit ri, input bit ro, input bit ba);
    bus.ir_load  = ld;  bus.ir_in  = din;
    bus.gra      = a;   bus.grb    = b;   bus.grc  = c;
    bus.rin      = ri;  bus.rout   = ro;  bus.baout = ba;
    bus8.ir_load = ld;  bus8.ir_in = din;
    bus8.gra     = a;   bus8.grb   = b;   bus8.grc  = c;
    bus8.rin     = ri;  bus8.rout  = ro;  bus8.baout = ba;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    clear = 1'b0;
    set_ctl(0, 32'h0, 0, 0, 0, 0, 0, 0);
    #1;
    n_checks++; if (bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_init_valid: got %b want 0", bus.valid_out); end
    n_checks++; if (bus.reg_in !== 16'h0) begin n_fail++; $display("FAIL reset_init_reg_in: got %h want 0000", bus.reg_in); end
    #1 clear = 1'b1;
    set_ctl(1, make_ir(1, 5, 3, 2, 0), 0, 0, 0, 0, 0, 0);
    step();
    set_ctl(0, 32'h0, 1, 0, 0, 1, 0, 0);
    step();
    n_checks++; if (bus.reg_in !== 16'h0020) begin n_fail++; $display("FAIL reset_pre_pulse: got %h want 0020", bus.reg_in); end
    n_checks++; if (bus.opcode !== 5'd1) begin n_fail++; $display("FAIL reset_pre_opcode: got %h want 01", bus.opcode); end
    // Clear mid-cycle with rin still held, no clock edge in between
    #2 clear = 1'b0;
    #1;
    n_checks++; if (bus.reg_in !== 16'h0) begin n_fail++; $display("FAIL reset_async_reg_in: got %h want 0000", bus.reg_in); end
    n_checks++; if (bus.reg_out !== 16'h0) begin n_fail++; $display("FAIL reset_async_reg_out: got %h want 0000", bus.reg_out); end
    n_checks++; if (bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_async_valid: got %b want 0", bus.valid_out); end
    n_checks++; if (bus.sel_err !== 1'b0) begin n_fail++; $display("FAIL reset_async_sel_err: got %b want 0", bus.sel_err); end
    n_checks++; if (bus.opcode !== 5'd0) begin n_fail++; $display("FAIL reset_async_opcode: got %h want 00", bus.opcode); end
    n_checks++; if (bus.c_sign_extended !== 32'h0) begin n_fail++; $display("FAIL reset_async_csx: got %h want 00000000", bus.c_sign_extended); end
    set_ctl(0, 32'h0, 0, 0, 0, 0, 0, 0);
    #1 clear = 1'b1;
    step();
    n_checks++; if (bus.valid_out !== 1'b0 || bus.reg_in !== 16'h0) begin n_fail++; $display("FAIL reset_after_release: got valid=%b reg_in=%h want 0/0000", bus.valid_out, bus.reg_in); end
  endtask

  task automatic test_decode();
    set_ctl(1, 32'h0A990000, 0, 0, 0, 0, 0, 0);
    step();
    set_ctl(0, 32'h0, 0, 0, 0, 0, 0, 0);
    n_checks++; if (bus.opcode !== 5'd1) begin n_fail++; $display("FAIL decode_opcode: got %h want 01", bus.opcode); end
    n_checks++; if (bus.c_sign_extended !== 32'h00010000) begin n_fail++; $display("FAIL decode_csx_pos: got %h want 00010000", bus.c_sign_extended); end
    set_ctl(1, 32'h0007FFFF, 0, 0, 0, 0, 0, 0);
    step();
    set_ctl(0, 32'h0, 0, 0, 0, 0, 0, 0);
    n_checks++; if (bus.c_sign_extended !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL decode_csx_neg: got %h want ffffffff", bus.c_sign_extended); end
    n_checks++; if (bus.opcode !== 5'd0) begin n_fail++; $display("FAIL decode_opcode_zero: got %h want 00", bus.opcode); end
  endtask

  task automatic test_field_select();
    set_ctl(1, 32'h0A990000, 0, 0, 0, 0, 0, 0);
    step();
    set_ctl(0, 32'h0, 1, 0, 0, 1, 0, 0);
    step();
    n_checks++; if (bus.reg_in !== 16'h0020) begin n_fail++; $display("FAIL sel_ra_reg_in: got %h want 0020", bus.reg_in); end
    n_checks++; if (bus.valid_out !== 1'b1) begin n_fail++; $display("FAIL sel_ra_valid: got %b want 1", bus.valid_out); end
    n_checks++; if (bus.reg_out !== 16'h0 || bus.sel_err !== 1'b0) begin n_fail++; $display("FAIL sel_ra_side: got reg_out=%h sel_err=%b want 0000/0", bus.reg_out, bus.sel_err); end
    set_ctl(0, 32'h0, 0, 1, 0, 0, 1, 0);
    step();
    n_checks++; if (bus.reg_out !== 16'h0008) begin n_fail++; $display("FAIL sel_rb_reg_out: got %h want 0008", bus.reg_out); end
    n_checks++; if (bus.reg_in !== 16'h0) begin n_fail++; $display("FAIL sel_rb_reg_in: got %h want 0000", bus.reg_in); end
    set_ctl(0, 32'h0, 0, 0, 1, 1, 1, 0);
    step();
    n_checks++; if (bus.reg_in !== 16'h0004 || bus.reg_out !== 16'h0004) begin n_fail++; $display("FAIL sel_rc_both: got reg_in=%h reg_out=%h want 0004/0004", bus.reg_in, bus.reg_out); end
    set_ctl(0, 32'h0, 0, 0, 0, 0, 0, 0);
    step();
    n_checks++; if (bus.valid_out !== 1'b0 || bus.reg_in !== 16'h0 || bus.reg_out !== 16'h0) begin n_fail++; $display("FAIL sel_hold_idle: got valid=%b reg_in=%h reg_out=%h want 0/0000/0000", bus.valid_out, bus.reg_in, bus.reg_out); end
  endtask

  task automatic test_priority();
    set_ctl(0, 32'h0, 1, 0, 1, 1, 0, 0);
    step();
    n_checks++; if (bus.reg_in !== 16'h0020) begin n_fail++; $display("FAIL prio_reg_in: got %h want 0020", bus.reg_in); end
    n_checks++; if (bus.sel_err !== 1'b1) begin n_fail++; $display("FAIL prio_sel_err: got %b want 1", bus.sel_err); end
  endtask

  task automatic test_baout();
    set_ctl(1, make_ir(0, 5, 0, 2, 0), 0, 0, 0, 0, 0, 0);
    step();
    set_ctl(0, 32'h0, 0, 1, 0, 0, 0, 1);
    step();
    n_checks++; if (bus.reg_out !== 16'h0) begin n_fail++; $display("FAIL ba_r0_reg_out: got %h want 0000", bus.reg_out); end
    n_checks++; if (bus.ba_zero !== 1'b1) begin n_fail++; $display("FAIL ba_r0_ba_zero: got %b want 1", bus.ba_zero); end
    set_ctl(1, make_ir(0, 5, 7, 2, 0), 0, 0, 0, 0, 0, 0);
    step();
    set_ctl(0, 32'h0, 0, 1, 0, 0, 0, 1);
    step();
    n_checks++; if (bus.reg_out !== 16'h0080) begin n_fail++; $display("FAIL ba_r7_reg_out: got %h want 0080", bus.reg_out); end
    n_checks++; if (bus.ba_zero !== 1'b0) begin n_fail++; $display("FAIL ba_r7_ba_zero: got %b want 0", bus.ba_zero); end
  endtask

  task automatic test_out_of_range();
    set_ctl(1, make_ir(0, 12, 7, 2, 0), 0, 0, 0, 0, 0, 0);
    step();
    set_ctl(0, 32'h0, 1, 0, 0, 1, 0, 0);
    step();
    n_checks++; if (bus8.reg_in !== 8'h00) begin n_fail++; $display("FAIL oor_reg_in: got %h want 00", bus8.reg_in); end
    n_checks++; if (bus8.sel_err !== 1'b1) begin n_fail++; $display("FAIL oor_sel_err: got %b want 1", bus8.sel_err); end
    n_checks++; if (bus.reg_in !== 16'h1000 || bus.sel_err !== 1'b0) begin n_fail++; $display("FAIL oor_wide_inrange: got reg_in=%h sel_err=%b want 1000/0", bus.reg_in, bus.sel_err); end
    set_ctl(0, 32'h0, 0, 1, 0, 0, 1, 0);
    step();
    n_checks++; if (bus8.reg_out !== 8'h80 || bus8.sel_err !== 1'b0) begin n_fail++; $display("FAIL oor_top_reg: got reg_out=%h sel_err=%b want 80/0", bus8.reg_out, bus8.sel_err); end
  endtask

  task automatic test_bypass();
    logic [15:0] exp_in;
`ifdef SELENC_IR_BYPASS_EN
    exp_in = 16'h0020;
`else
    exp_in = 16'h0004;
`endif
    set_ctl(1, make_ir(0, 2, 0, 0, 0), 0, 0, 0, 0, 0, 0);
    step();
    set_ctl(1, make_ir(0, 5, 0, 0, 0), 1, 0, 0, 1, 0, 0);
    step();
    n_checks++; if (bus.reg_in !== exp_in) begin n_fail++; $display("FAIL bypass_load_sel: got %h want %h", bus.reg_in, exp_in); end
    set_ctl(0, 32'h0, 1, 0, 0, 1, 0, 0);
    step();
    n_checks++; if (bus.reg_in !== 16'h0020) begin n_fail++; $display("FAIL bypass_next_sel: got %h want 0020", bus.reg_in); end
  endtask

  task automatic test_random();
    logic [31:0] m_ir;
    logic [31:0] din;
    logic [31:0] e_csx;
    logic [15:0] e_in, e_out, e8_in, e8_out;
    bit e_ba, e_err, e_valid, e8_ba, e8_err, e8_valid;
    bit ld, a, b, c, ri, ro, ba;
    m_ir = $urandom;
    set_ctl(1, m_ir, 0, 0, 0, 0, 0, 0);
    step();
    for (int it = 0; it < 300; it++) begin
      ld  = ($urandom_range(0, 3) == 0);
      din = $urandom;
      a   = $urandom_range(0, 1) != 0;
      b   = $urandom_range(0, 1) != 0;
      c   = $urandom_range(0, 1) != 0;
      ri  = $urandom_range(0, 2) == 0;
      ro  = $urandom_range(0, 2) == 0;
      ba  = $urandom_range(0, 2) == 0;
      model(m_ir, din, ld, a, b, c, ri, ro, ba, 16, e_in, e_out, e_ba, e_err, e_valid);
      model(m_ir, din, ld, a, b, c, ri, ro, ba, 8, e8_in, e8_out, e8_ba, e8_err, e8_valid);
      set_ctl(ld, din, a, b, c, ri, ro, ba);
      step();
      if (ld) m_ir = din;
      e_csx = (m_ir & 32'h0007FFFF) | (m_ir[18] ? 32'hFFF80000 : 32'h0);
      n_checks++; if (bus.reg_in !== e_in || bus.reg_out !== e_out) begin n_fail++; $display("FAIL rand16_vec it=%0d: got in=%h out=%h want in=%h out=%h", it, bus.reg_in, bus.reg_out, e_in, e_out); end
      n_checks++; if ({bus.ba_zero, bus.sel_err, bus.valid_out} !== {e_ba, e_err, e_valid}) begin n_fail++; $display("FAIL rand16_flags it=%0d: got %b%b%b want %b%b%b", it, bus.ba_zero, bus.sel_err, bus.valid_out, e_ba, e_err, e_valid); end
      n_checks++; if ({8'h0, bus8.reg_in} !== e8_in || {8'h0, bus8.reg_out} !== e8_out) begin n_fail++; $display("FAIL rand8_vec it=%0d: got in=%h out=%h want in=%h out=%h", it, bus8.reg_in, bus8.reg_out, e8_in, e8_out); end
      n_checks++; if ({bus8.ba_zero, bus8.sel_err, bus8.valid_out} !== {e8_ba, e8_err, e8_valid}) begin n_fail++; $display("FAIL rand8_flags it=%0d: got %b%b%b want %b%b%b", it, bus8.ba_zero, bus8.sel_err, bus8.valid_out, e8_ba, e8_err, e8_valid); end
      n_checks++; if ($countones(bus.reg_in) > 1 || $countones(bus.reg_out) > 1) begin n_fail++; $display("FAIL rand_onehot it=%0d: got in=%h out=%h want at most one bit", it, bus.reg_in, bus.reg_out); end
      n_checks++; if (bus.opcode !== 5'(m_ir >> 27) || bus.c_sign_extended !== e_csx) begin n_fail++; $display("FAIL rand_decode it=%0d: got op=%h csx=%h want op=%h csx=%h", it, bus.opcode, bus.c_sign_extended, 5'(m_ir >> 27), e_csx); end
    end
    set_ctl(0, 32'h0, 0, 0, 0, 0, 0, 0);
    step();
  endtask

  initial begin
    test_reset();
    test_decode();
    test_field_select();
    test_priority();
    test_baout();
    test_out_of_range();
    test_bypass();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
